// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder sequencer: one shared 4-bit full-adder slice adds NIBBLES*4-bit operands,
// one nibble per clock, least-significant nibble first, with a start/ready/done handshake.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 cin,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 C,
  output logic                 V
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, s_q, s_d;
  logic              carry_q, carry_d, c_q, c_d, v_q, v_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [3:0]        slice_sum;
  logic              slice_co, slice_c3;

  // Ripple slice of full-adder cells; bit 0 carry-in comes from the carry register.
  always_comb begin
    logic c;
    c         = carry_q;
    slice_c3  = 1'b0;
    slice_sum = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) slice_c3 = c;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    slice_co = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          cnt_d   = '0;
          s_d     = '0;
          c_d     = 1'b0;
          v_d     = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int n = 0; n < int'(NIBBLES); n++) begin
          if (cnt_q == CntW'(n)) s_d[4*n +: 4] = slice_sum;
        end
        carry_d = slice_co;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (cnt_q == CntW'(NIBBLES - 1)) begin
          c_d     = slice_co;
          v_d     = slice_c3 ^ slice_co;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign S     = s_q;
  assign C     = c_q;
  assign V     = v_q;

endmodule
